// File: rtl/tile_pkg.sv
// Shared widths, color bundle and round-robin pointer helper for the tile ROM
// request path.
package tile_pkg;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 8;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr upward,
// ptr moves past the winner whenever the grant is consumed.
module rr_arbiter
  import tile_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] win;
  logic [PW:0]   idx;

  // Scan from the farthest offset down so the nearest requester overwrites.
  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (req[idx[PW-1:0]]) begin
        grant                = '0;
        grant[idx[PW-1:0]]   = 1'b1;
        win                  = idx[PW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= PW'(rr_next(int'(win), N));
  end
endmodule

// File: rtl/tile_rom_arbiter.sv
// Shares one combinational Rom_tile among NUM_REQ pixel requesters: grant,
// register the address (stage 1), register the ROM color tagged one-hot (stage 2).
module tile_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int COORD_W = tile_pkg::COORD_W,
  parameter int COLOR_W = tile_pkg::COLOR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [COORD_W-1:0]         rom_qx,
  output logic [COORD_W-1:0]         rom_qy,
  input  logic [COLOR_W-1:0]         rom_r,
  input  logic [COLOR_W-1:0]         rom_g,
  input  logic [COLOR_W-1:0]         rom_b,
  input  logic                       rom_visible,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [COLOR_W-1:0]         rsp_r,
  output logic [COLOR_W-1:0]         rsp_g,
  output logic [COLOR_W-1:0]         rsp_b,
  output logic                       rsp_visible,
  output logic                       busy
);
  logic [NUM_REQ-1:0] grant;
  logic               xfer;
  logic               s1_v;
  logic [NUM_REQ-1:0] s1_id;
  logic [COORD_W-1:0] sel_x, sel_y;

  assign req_ready = en ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .grant   (grant)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_x = req_x[i*COORD_W +: COORD_W];
        sel_y = req_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // Stage 1: address to ROM; address holds between lookups.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s1_id  <= '0;
      rom_qx <= '0;
      rom_qy <= '0;
    end else begin
      s1_v <= xfer;
      if (xfer) begin
        s1_id  <= req_ready;
        rom_qx <= sel_x;
        rom_qy <= sel_y;
      end
    end
  end

  // Stage 2: capture ROM result; no backpressure, strobe lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= '0;
      rsp_r       <= '0;
      rsp_g       <= '0;
      rsp_b       <= '0;
      rsp_visible <= 1'b0;
    end else begin
      rsp_valid <= s1_v ? s1_id : '0;
      if (s1_v) begin
        rsp_r       <= rom_r;
        rsp_g       <= rom_g;
        rsp_b       <= rom_b;
        rsp_visible <= rom_visible;
      end
    end
  end

  assign busy = s1_v | (|rsp_valid);
endmodule

// File: tb/tb_tile_rom_arbiter.sv
// Directed vector table plus randomized traffic against a queue-based
// reference of the arbiter and two-stage ROM pipeline.
module tb_tile_rom_arbiter;
  import tile_pkg::*;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int KW = 8;

  logic            clk = 1'b0;
  logic            rst, en;
  logic [N-1:0]    req_valid;
  logic [N*CW-1:0] req_x, req_y;
  logic [N-1:0]    req_ready;
  logic [CW-1:0]   rom_qx, rom_qy;
  logic [KW-1:0]   rom_r, rom_g, rom_b;
  logic            rom_visible;
  logic [N-1:0]    rsp_valid;
  logic [KW-1:0]   rsp_r, rsp_g, rsp_b;
  logic            rsp_visible;
  logic            busy;

  always #5 clk = ~clk;

  tile_rom_arbiter #(.NUM_REQ(N), .COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .req_ready(req_ready), .rom_qx(rom_qx), .rom_qy(rom_qy),
    .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b), .rom_visible(rom_visible),
    .rsp_valid(rsp_valid), .rsp_r(rsp_r), .rsp_g(rsp_g), .rsp_b(rsp_b),
    .rsp_visible(rsp_visible), .busy(busy)
  );

  // Stand-in for Rom_tile: arbitrary but coordinate-dependent colors.
  function automatic rgb_t rom_color(input int x, input int y);
    rgb_t c;
    c.r = 8'(x ^ y);
    c.g = 8'(x + 2 * y);
    c.b = 8'((x >> 2) + (y >> 1) + 7);
    return c;
  endfunction

  function automatic logic rom_vis(input int x, input int y);
    return (x < 640) && (y < 480);
  endfunction

  rgb_t rom_c;
  always_comb begin
    rom_c       = rom_color(int'(rom_qx), int'(rom_qy));
    rom_r       = rom_c.r;
    rom_g       = rom_c.g;
    rom_b       = rom_c.b;
    rom_visible = rom_vis(int'(rom_qx), int'(rom_qy));
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pending lookups queued with the edge number their response is due.
  typedef struct {
    int id;
    int x;
    int y;
    int due;
  } look_t;

  look_t        pend[$];
  int           m_ptr = 0;
  int           cyc = 0;
  int           m_qx = 0, m_qy = 0;
  logic [N-1:0] m_rsp = '0;
  rgb_t         m_col = '0;
  logic         m_vis = 1'b0;

  function automatic logic [N-1:0] model_ready();
    if (!en) return '0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic tick();
    logic [N-1:0] g;
    look_t l;
    #1;
    g = model_ready();
    chk("req_ready", int'(req_ready), int'(g));
    @(posedge clk);
    cyc++;
    if (rst) begin
      pend.delete();
      m_ptr = 0; m_qx = 0; m_qy = 0;
      m_rsp = '0; m_col = '0; m_vis = 1'b0;
    end else begin
      m_rsp = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        l     = pend.pop_front();
        m_rsp = N'(1) << l.id;
        m_col = rom_color(l.x, l.y);
        m_vis = rom_vis(l.x, l.y);
      end
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          l.id  = i;
          l.x   = int'(req_x[i*CW +: CW]);
          l.y   = int'(req_y[i*CW +: CW]);
          l.due = cyc + 1;
          pend.push_back(l);
          m_qx  = l.x;
          m_qy  = l.y;
          m_ptr = (i + 1) % N;
        end
      end
    end
    @(negedge clk);
    chk("rom_qx", int'(rom_qx), m_qx);
    chk("rom_qy", int'(rom_qy), m_qy);
    chk("rsp_valid", int'(rsp_valid), int'(m_rsp));
    chk("rsp_r", int'(rsp_r), int'(m_col.r));
    chk("rsp_g", int'(rsp_g), int'(m_col.g));
    chk("rsp_b", int'(rsp_b), int'(m_col.b));
    chk("rsp_visible", int'(rsp_visible), int'(m_vis));
    chk("busy", int'(busy), int'(pend.size() > 0 || m_rsp != '0));
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] v;
    int         x1;
    int         y1;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[23];

  initial begin
    // Rows run back to back; expected ready derived by hand from the pointer rule.
    tbl[0]  = '{1'b1, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[1]  = '{1'b1, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[2]  = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[4]  = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[5]  = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[6]  = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 4'b0010, 430, 160, 4'b0010};   // ptr -> 2
    tbl[8]  = '{1'b0, 1'b1, 4'b1111, -1, -1, 4'b0100};     // ptr -> 3
    tbl[9]  = '{1'b0, 1'b1, 4'b1111, -1, -1, 4'b1000};     // ptr -> 0
    tbl[10] = '{1'b0, 1'b1, 4'b1111, -1, -1, 4'b0001};
    tbl[11] = '{1'b0, 1'b1, 4'b1111, -1, -1, 4'b0010};     // ptr -> 2
    tbl[12] = '{1'b0, 1'b1, 4'b1001, -1, -1, 4'b1000};     // skip over 2
    tbl[13] = '{1'b0, 1'b1, 4'b1001, -1, -1, 4'b0001};
    tbl[14] = '{1'b0, 1'b1, 4'b1001, -1, -1, 4'b1000};
    tbl[15] = '{1'b0, 1'b1, 4'b0001, -1, -1, 4'b0001};     // ptr -> 1
    tbl[16] = '{1'b0, 1'b0, 4'b0001, -1, -1, 4'b0000};
    tbl[17] = '{1'b0, 1'b0, 4'b1111, -1, -1, 4'b0000};
    tbl[18] = '{1'b0, 1'b1, 4'b1111, 1023, 1023, 4'b0010};
    tbl[19] = '{1'b1, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[20] = '{1'b0, 1'b1, 4'b1111, -1, -1, 4'b0001};
    tbl[21] = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};
    tbl[22] = '{1'b0, 1'b1, 4'b0000, -1, -1, 4'b0000};

    rst = 1'b1; en = 1'b0; req_valid = '0; req_x = '0; req_y = '0;
    @(negedge clk);

    for (int r = 0; r < 23; r++) begin
      rst       = tbl[r].rst;
      en        = tbl[r].en;
      req_valid = tbl[r].v;
      for (int i = 0; i < N; i++) begin
        req_x[i*CW +: CW] = CW'(418 + i);
        req_y[i*CW +: CW] = CW'(158 + i);
      end
      if (tbl[r].x1 >= 0) begin
        req_x[CW +: CW] = CW'(tbl[r].x1);
        req_y[CW +: CW] = CW'(tbl[r].y1);
      end
      #1;
      chk($sformatf("tbl%0d_ready", r), int'(req_ready), int'(tbl[r].exp));
      tick();
      // Single-requester lookup at (430,160): address lands one edge after grant.
      if (r == 7) begin
        chk("single_qx", int'(rom_qx), 430);
        chk("single_qy", int'(rom_qy), 160);
      end
      if (r == 8) chk("single_rsp", int'(rsp_valid), 4'b0010);
      // Mid-op reset: the lookup granted in row 18 must never respond.
      if (r == 19) chk("rst_drop", int'(rsp_valid), 0);
    end

    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 39) == 0);
      en        = ($urandom_range(0, 7) != 0);
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_x[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? CW'(1023) : CW'($urandom_range(0, 1023));
        req_y[i*CW +: CW] = CW'($urandom_range(0, 1023));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
